// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - Ascon permutation round controller (optional watchdog: ASCON_PERM_CTRL_WATCHDOG_EN)
// Sequences p^a / p^b permutations over an external round counter and counts completions.
module ascon_perm_ctrl #(
    parameter int ROUND_A_P = 12,
    parameter int ROUND_B_P = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_mode_i,
    output logic        req_ready_o,
    input  logic        abort_i,
    output logic        load_a_o,
    output logic        load_b_o,
    output logic        round_en_o,
    input  logic        round_last_i,
    output logic        state_we_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] perm_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] perm_cnt_q;
    logic        accept;
    logic        timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        load_a_o    = 1'b0;
        load_b_o    = 1'b0;
        round_en_o  = 1'b0;
        state_we_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = rst_n && !abort_i;
                accept      = req_valid_i && req_ready_o;
                load_a_o    = accept && !req_mode_i;
                load_b_o    = accept && req_mode_i;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    round_en_o = 1'b1;
                    state_we_o = 1'b1;
                    if (round_last_i) begin
                        state_d = DONE;
                    end else if (timeout) begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = !abort_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_cnt_q <= 16'h0000;
        end else if (done_o) begin
            perm_cnt_q <= perm_cnt_q + 16'h0001;
        end
    end

    assign perm_cnt_o = perm_cnt_q;

`ifdef ASCON_PERM_CTRL_WATCHDOG_EN
    // The latched mode only selects the watchdog limit.
    logic       mode_q;
    logic [7:0] run_cnt_q;
    logic [7:0] limit;
    logic       err_q;

    assign limit   = mode_q ? 8'(ROUND_B_P - 1) : 8'(ROUND_A_P - 1);
    assign timeout = (state_q == RUN) && (run_cnt_q == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            run_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                mode_q    <= req_mode_i;
                run_cnt_q <= 8'd0;
                err_q     <= 1'b0;
            end else if (state_q == RUN) begin
                run_cnt_q <= run_cnt_q + 8'd1;
                if (!abort_i && !round_last_i && timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - randomized self-checking bench for ascon_perm_ctrl
// Each operation is predicted from its mode, final-round position and abort position.
module tb_ascon_perm_ctrl;

    localparam int RA = 12;
    localparam int RB = 8;
    localparam int WIN = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_mode = 1'b0;
    logic        abort = 1'b0;
    logic        round_last = 1'b0;
    logic        req_ready;
    logic        load_a;
    logic        load_b;
    logic        round_en;
    logic        state_we;
    logic        busy;
    logic        done;
    logic [15:0] perm_cnt;
    logic        err;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic        exp_err = 1'b0;
`ifdef ASCON_PERM_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    ascon_perm_ctrl #(.ROUND_A_P(RA), .ROUND_B_P(RB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_mode_i   (req_mode),
        .req_ready_o  (req_ready),
        .abort_i      (abort),
        .load_a_o     (load_a),
        .load_b_o     (load_b),
        .round_en_o   (round_en),
        .round_last_i (round_last),
        .state_we_o   (state_we),
        .busy_o       (busy),
        .done_o       (done),
        .perm_cnt_o   (perm_cnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // last_at / abort_at are 1-based RUN-cycle positions; 0 means never.
    task automatic run_op(input logic mode, input int last_at, input int abort_at);
        int en_cnt = 0, we_cnt = 0, rdy_cnt = 0, ld_cnt = 0, done_cnt = 0, done_at = 0;
        int limit, active, exp_en;
        bit completes;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_mode  = mode;
        abort     = 1'b0;
        round_last = 1'b0;
        @(negedge clk);
        check("accept_ready", 32'(req_ready), 32'd1);
        check("accept_load_a", 32'(load_a), 32'(!mode));
        check("accept_load_b", 32'(load_b), 32'(mode));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_err = 1'b0;
        for (int k = 1; k <= WIN; k++) begin
            round_last = (k == last_at);
            abort      = (k == abort_at);
            @(negedge clk);
            en_cnt  += int'(round_en);
            we_cnt  += int'(state_we);
            rdy_cnt += int'(req_ready);
            ld_cnt  += int'(load_a) + int'(load_b);
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            @(posedge clk);
            #1;
        end
        round_last = 1'b0;
        abort = 1'b0;

        limit = mode ? RB : RA;
        completes = 1'b0;
        if (abort_at != 0 && (last_at == 0 || abort_at <= last_at) && (!WD || abort_at <= limit)) begin
            exp_en = abort_at - 1;
            active = abort_at;
        end else if (WD && (last_at == 0 || last_at > limit)) begin
            exp_en  = limit;
            active  = limit;
            exp_err = 1'b1;
        end else begin
            exp_en = last_at;
            active = last_at + 1;
            completes = (abort_at != last_at + 1);
        end
        if (completes) exp_cnt = exp_cnt + 16'd1;

        check("round_en_cycles", 32'(en_cnt), 32'(exp_en));
        check("state_we_cycles", 32'(we_cnt), 32'(exp_en));
        check("done_pulses", 32'(done_cnt), 32'(completes));
        if (completes) check("done_latency", 32'(done_at + 1), 32'(last_at + 2));
        check("ready_cycles", 32'(rdy_cnt), 32'(WIN - active));
        check("stray_load", 32'(ld_cnt), 32'd0);
        check("perm_cnt", 32'(perm_cnt), 32'(exp_cnt));
        check("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int lim, last, ab;
        logic m;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_round_en", 32'(round_en), 32'd0);
        check("rst_perm_cnt", 32'(perm_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        run_op(1'b0, 12, 0);
        run_op(1'b1, 8, 0);
        run_op(1'b0, 12, 5);
        run_op(1'b0, 3, 0);
        run_op(1'b1, 2, 3);

        @(posedge clk);
        #1;
        req_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", 32'(req_ready), 32'd0);
        check("abort_idle_load", 32'(load_a) + 32'(load_b), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_ready_after", 32'(req_ready), 32'd1);

        force dut.perm_cnt_q = 16'hFFFF;
        #1;
        release dut.perm_cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        check("preload", 32'(perm_cnt), 32'h0000FFFF);
        run_op(1'b1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            lim = m ? RB : RA;
            last = int'($urandom_range(1, lim));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, last + 1)) : 0;
            run_op(m, last, ab);
        end

        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_mode = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_round_en", 32'(round_en), 32'd0);
        check("midop_rst_perm_cnt", 32'(perm_cnt), 32'd0);
        exp_cnt = 16'h0000;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(1'b0, 4, 0);

        if (WD) begin
            run_op(1'b1, 0, 0);
            run_op(1'b0, 0, 0);
            run_op(1'b1, 8, 0);
            run_op(1'b0, 0, 12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
